// File: rtl/ram_pkg.sv
// ram_pkg: shared types for the behavioural RAM responder.
//   word_t       32-bit data word
//   ramstate_t   requester-visible RAM state (FREE/BUSY/ACCESS/ERROR)
//   rsp_state_t  internal responder FSM state (IDLE/WAIT/ACCESS/ERROR)
// The FSM encoding matches the ramstate encoding one-to-one. The mapping
// function keeps the two types decoupled anyway.
package ram_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    RSP_IDLE   = 2'd0,
    RSP_WAIT   = 2'd1,
    RSP_ACCESS = 2'd2,
    RSP_ERROR  = 2'd3
  } rsp_state_t;

  // Requester-visible state presented while the FSM sits in a given state.
  function automatic ramstate_t state_to_ramstate(input rsp_state_t s);
    ramstate_t r;
    case (s)
      RSP_WAIT:   r = RAM_BUSY;
      RSP_ACCESS: r = RAM_ACCESS;
      RSP_ERROR:  r = RAM_ERROR;
      default:    r = RAM_FREE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: single-port synchronous memory with a registered read port.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset. It clears only the read register,
//          never the storage.
//   addr   word index
//   we     write enable. wdata is stored at addr on the edge.
//   wdata  write data
//   re     read enable. rdata takes mem[addr] on the edge and holds it otherwise.
//   rdata  registered read data
// Every word powers up holding INIT_WORD.
module ram_array
  import ram_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter word_t INIT_WORD = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  word_t             wdata,
  input  logic              re,
  output word_t             rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The declaration initialiser gives the power-up contents. Reset does not
  // touch the storage.
  word_t mem [DEPTH] = '{default: INIT_WORD};

  word_t rdata_q;
  word_t rdata_d;

  // The read register holds its value unless a read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory-side end of the cpu_ram interface. It answers
// ramREN/ramWEN with BUSY for LAT cycles, then exactly one ACCESS cycle.
// A conflicting or out-of-range request gets one ERROR cycle instead.
// Ports:
//   CLK       rising-edge clock
//   nRST      synchronous active-low reset (the array contents survive it)
//   ramaddr   byte address. Bits [1:0] are ignored; the word index is [ADDR_W+1:2].
//   ramstore  write data
//   ramREN    read request, level
//   ramWEN    write request, level
//   ramload   read data. It updates in the ACCESS cycle of a read and holds otherwise.
//   ramstate  FREE=0 BUSY=1 ACCESS=2 ERROR=3, registered
// Optional build macro RAM_STATS_EN adds rd_count/wr_count. These are
// saturating counters of completed reads and writes, cleared by nRST.
module ram_responder
  import ram_pkg::*;
#(
  parameter int    LAT       = 2,
  parameter int    ADDR_W    = 12,
  parameter word_t INIT_WORD = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
`ifdef RAM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  // The counter only ever holds LAT-1 down to 0.
  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT);

  rsp_state_t        state_q, state_d;
  ramstate_t         ramstate_q, ramstate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  word_t             store_q, store_d;
  logic              op_wr_q, op_wr_d;

  logic              req_any;
  logic              req_bad;
  logic              req_changed;
  logic              acc_we;
  logic              acc_re;
  logic [31:0]       acc_addr;
  word_t             acc_wdata;
  logic              mem_we;
  logic              mem_re;

  // Request classification. An out-of-range address only matters when a
  // request is actually raised. In WAIT, any change to op, address, or the
  // store data of a write abandons the latched transaction.
  always_comb begin
    req_any     = ramREN | ramWEN;
    req_bad     = (ramREN & ramWEN) || ((ramaddr >> (ADDR_W + 2)) != 32'd0);
    req_changed = (ramREN != !op_wr_q) || (ramWEN != op_wr_q) ||
                  (ramaddr != addr_q) || (op_wr_q && (ramstore != store_q));
  end

  // Next-state logic. The memory operation is issued on the edge that enters
  // ACCESS. With LAT=0 that edge is the one that first samples the request,
  // so the live inputs feed the array directly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    store_d   = store_q;
    op_wr_d   = op_wr_q;
    acc_we    = 1'b0;
    acc_re    = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = store_q;
    case (state_q)
      RSP_IDLE: begin
        if (req_any && req_bad) begin
          state_d = RSP_ERROR;
        end else if (req_any) begin
          addr_d  = ramaddr;
          store_d = ramstore;
          op_wr_d = ramWEN;
          if (LAT > 0) begin
            state_d = RSP_WAIT;
            cnt_d   = CNT_W'(LAT - 1);
          end else begin
            state_d   = RSP_ACCESS;
            acc_we    = ramWEN;
            acc_re    = ramREN;
            acc_addr  = ramaddr;
            acc_wdata = ramstore;
          end
        end
      end
      RSP_WAIT: begin
        if (req_changed) begin
          state_d = RSP_IDLE;
        end else if (cnt_q == '0) begin
          state_d = RSP_ACCESS;
          acc_we  = op_wr_q;
          acc_re  = !op_wr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
    ramstate_d = state_to_ramstate(state_d);
  end

  // A reset edge must never commit a write, even if the FSM was about to
  // enter ACCESS on that edge.
  always_comb begin
    mem_we = acc_we & nRST;
    mem_re = acc_re & nRST;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= RSP_IDLE;
      ramstate_q <= RAM_FREE;
      cnt_q      <= '0;
      addr_q     <= '0;
      store_q    <= '0;
      op_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramstate_q <= ramstate_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      op_wr_q    <= op_wr_d;
    end
  end

  ram_array #(
    .ADDR_W    (ADDR_W),
    .INIT_WORD (INIT_WORD)
  ) u_array (
    .clk   (CLK),
    .rst_n (nRST),
    .addr  (acc_addr[ADDR_W+1:2]),
    .we    (mem_we),
    .wdata (acc_wdata),
    .re    (mem_re),
    .rdata (ramload)
  );

  assign ramstate = ramstate_q;

`ifdef RAM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Only completed accesses count. Both counters stick at all-ones.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (mem_re && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (mem_we && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: drives two responders, one with LAT=2 and one with LAT=0.
// Transactions are scripted or randomised and checked against a behavioural
// model. The model is a word-keyed associative array plus the expected
// BUSY/ACCESS/ERROR timeline of each request.
module tb_ram_responder;

  localparam int          ADDR_W   = 12;
  localparam logic [31:0] INIT     = 32'h0;
  localparam logic [31:0] S_FREE   = 32'd0;
  localparam logic [31:0] S_BUSY   = 32'd1;
  localparam logic [31:0] S_ACCESS = 32'd2;
  localparam logic [31:0] S_ERROR  = 32'd3;

  logic             clk = 1'b0;
  logic [1:0]       rst_n;
  logic [1:0]       ren;
  logic [1:0]       wen;
  logic [1:0][31:0] addr_v;
  logic [1:0][31:0] store_v;
  logic [31:0]      load_a, load_b;
  logic [1:0]       state_a, state_b;
`ifdef RAM_STATS_EN
  logic [31:0]      rdc_a, wrc_a, rdc_b, wrc_b;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [int];
  logic [31:0] exp_load [2];
  int          exp_rd [2];
  int          exp_wr [2];

  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .ADDR_W(ADDR_W), .INIT_WORD(INIT)) dut_a (
    .CLK(clk), .nRST(rst_n[0]), .ramaddr(addr_v[0]), .ramstore(store_v[0]),
    .ramREN(ren[0]), .ramWEN(wen[0]), .ramload(load_a), .ramstate(state_a)
`ifdef RAM_STATS_EN
    , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
  );

  ram_responder #(.LAT(0), .ADDR_W(ADDR_W), .INIT_WORD(INIT)) dut_b (
    .CLK(clk), .nRST(rst_n[1]), .ramaddr(addr_v[1]), .ramstore(store_v[1]),
    .ramREN(ren[1]), .ramWEN(wen[1]), .ramload(load_b), .ramstate(state_b)
`ifdef RAM_STATS_EN
    , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
  );

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] stateOf(input int d);
    return (d == 0) ? {30'b0, state_a} : {30'b0, state_b};
  endfunction

  function automatic logic [31:0] loadOf(input int d);
    return (d == 0) ? load_a : load_b;
  endfunction

  function automatic int keyOf(input int d, input logic [31:0] a);
    return d * 65536 + int'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic [31:0] modelRead(input int d, input logic [31:0] a);
    int k = keyOf(d, a);
    return model_mem.exists(k) ? model_mem[k] : INIT;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] s);
    ren[d]     = r;
    wen[d]     = w;
    addr_v[d]  = a;
    store_v[d] = s;
  endtask

  task automatic dropReq(input int d);
    ren[d] = 1'b0;
    wen[d] = 1'b0;
  endtask

  task automatic resetModel(input int d);
    exp_load[d] = 32'h0;
    exp_rd[d]   = 0;
    exp_wr[d]   = 0;
  endtask

  task automatic checkStats(input int d);
`ifdef RAM_STATS_EN
    checkOutput("rd_count", (d == 0) ? rdc_a : rdc_b, 32'(exp_rd[d]));
    checkOutput("wr_count", (d == 0) ? wrc_a : wrc_b, 32'(exp_wr[d]));
`endif
  endtask

  task automatic pulseReset(input int d);
    rst_n[d] = 1'b0;
    tick();
    checkOutput("rst_state", stateOf(d), S_FREE);
    checkOutput("rst_load", loadOf(d), 32'h0);
    resetModel(d);
    rst_n[d] = 1'b1;
    tick();
    checkOutput("rst_idle", stateOf(d), S_FREE);
    checkStats(d);
  endtask

  // One request from FREE. pert: 0 none, 1 move address, 2 swap op,
  // 3 change store data (aborts only a write), 4 reset during BUSY.
  task automatic doTxn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int pert);
    bit err = (rd && wr) || ((a >> (ADDR_W + 2)) != 32'd0);
    bit aborts;
    applyStimulus(d, rd, wr, a, wd);
    tick();
    if (err) begin
      checkOutput("error", stateOf(d), S_ERROR);
      dropReq(d);
      tick();
      checkOutput("error_free", stateOf(d), S_FREE);
      checkOutput("error_load_kept", loadOf(d), exp_load[d]);
      checkStats(d);
      return;
    end
    for (int i = 0; i < latOf(d); i++) begin
      checkOutput("busy", stateOf(d), S_BUSY);
      if (i == 0 && pert != 0) begin
        aborts = (pert != 3) || wr;
        case (pert)
          1:       addr_v[d] = a ^ 32'h4;
          2:       begin ren[d] = wr; wen[d] = rd; end
          3:       store_v[d] = ~wd;
          default: rst_n[d] = 1'b0;
        endcase
        if (aborts) begin
          tick();
          checkOutput("abort_free", stateOf(d), S_FREE);
          if (pert == 4) begin
            checkOutput("abort_rst_load", loadOf(d), 32'h0);
            resetModel(d);
            rst_n[d] = 1'b1;
          end else begin
            checkOutput("abort_load_kept", loadOf(d), exp_load[d]);
          end
          dropReq(d);
          tick();
          checkOutput("abort_idle", stateOf(d), S_FREE);
          checkStats(d);
          return;
        end
      end
      tick();
    end
    checkOutput("access", stateOf(d), S_ACCESS);
    if (rd) begin
      exp_load[d] = modelRead(d, a);
      exp_rd[d]++;
    end else begin
      model_mem[keyOf(d, a)] = wd;
      exp_wr[d]++;
    end
    checkOutput("ramload", loadOf(d), exp_load[d]);
    dropReq(d);
    tick();
    checkOutput("free_after", stateOf(d), S_FREE);
    checkStats(d);
  endtask

  int          d, r, pert;
  bit          rd, wr;
  logic [31:0] a, wd;

  initial begin
    rst_n   = 2'b00;
    ren     = 2'b00;
    wen     = 2'b00;
    addr_v  = '0;
    store_v = '0;
    resetModel(0);
    resetModel(1);
    repeat (3) tick();
    checkOutput("reset_state_a", stateOf(0), S_FREE);
    checkOutput("reset_load_a", loadOf(0), 32'h0);
    checkOutput("reset_state_b", stateOf(1), S_FREE);
    checkOutput("reset_load_b", loadOf(1), 32'h0);
    rst_n = 2'b11;
    tick();

    // Basic write then reads of the same word through different byte offsets.
    doTxn(0, 0, 1, 32'h40, 32'hDEADBEEF, 0);
    doTxn(0, 1, 0, 32'h40, 32'h0, 0);
    doTxn(0, 1, 0, 32'h41, 32'h0, 0);

    // Abort by moving the address, then show the word kept its old value.
    doTxn(0, 0, 1, 32'h80, 32'h1234, 1);
    doTxn(0, 1, 0, 32'h80, 32'h0, 0);

    // Conflicting and out-of-range requests leave the array alone.
    doTxn(0, 1, 1, 32'h10, 32'h77, 0);
    doTxn(0, 1, 0, 32'h0001_0000, 32'h0, 0);
    doTxn(0, 1, 0, 32'h10, 32'h0, 0);

    // Reset during BUSY drops the write. A normal reset keeps memory.
    doTxn(0, 0, 1, 32'h20, 32'hCAFEF00D, 4);
    doTxn(0, 1, 0, 32'h20, 32'h0, 0);
    doTxn(0, 0, 1, 32'h24, 32'hA5A5_0F0F, 0);
    pulseReset(0);
    doTxn(0, 1, 0, 32'h24, 32'h0, 0);

    // Mixed traffic followed by a reset, so the counters are seen clearing.
    doTxn(0, 0, 1, 32'h30, 32'h1111_2222, 2);
    doTxn(0, 1, 1, 32'h30, 32'h0, 0);
    doTxn(0, 0, 1, 32'h34, 32'h3333_4444, 0);
    doTxn(0, 1, 0, 32'h30, 32'h0, 3);
    pulseReset(0);

    // Zero-latency responder: a held read alternates ACCESS and FREE.
    doTxn(1, 0, 1, 32'h40, 32'h55AA_1234, 0);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    checkOutput("held_access1", stateOf(1), S_ACCESS);
    checkOutput("held_load1", loadOf(1), 32'h55AA_1234);
    tick();
    checkOutput("held_free", stateOf(1), S_FREE);
    tick();
    checkOutput("held_access2", stateOf(1), S_ACCESS);
    dropReq(1);
    exp_load[1] = 32'h55AA_1234;
    exp_rd[1]   = exp_rd[1] + 2;
    tick();
    checkOutput("held_done", stateOf(1), S_FREE);
    checkStats(1);

    // Random traffic on both responders over a small address window.
    for (int n = 0; n < 240; n++) begin
      d    = n % 2;
      r    = int'($urandom_range(0, 99));
      a    = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      wd   = $urandom;
      pert = 0;
      rd   = 1'b0;
      wr   = 1'b0;
      if (r < 40) begin
        rd = 1'b1;
      end else if (r < 75) begin
        wr = 1'b1;
      end else if (r < 81) begin
        rd = 1'b1;
        wr = 1'b1;
      end else if (r < 87) begin
        rd = r[0];
        wr = !r[0];
        a  = a | (32'h1 << $urandom_range(ADDR_W + 2, 31));
      end else begin
        wr   = r[1];
        rd   = !r[1];
        pert = (d == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      doTxn(d, rd, wr, a, wd, pert);
      if (n % 60 == 59) begin
        pulseReset(d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
